e_mdu: RTL and testbench
========================

// Module: e_mdu
// PURPOSE
//   Multiply/divide unit of the Execute stage. Consumes rd1E/rd2E and the decoded
//   MD operation of the instruction held in the D->E pipeline register, computes
//   mult/multu/div/divu over a fixed multi-cycle latency, and owns the HI/LO registers.
//   Drives busy to the hazard unit and honours Req: no architectural update on flush.
// PARAMETERS
//   MULT_CYCLES  5   busy cycles for mult/multu (>=1)
//   DIV_CYCLES   10  busy cycles for div/divu (>=1)
// PORTS
//   clk      in   1   clock, all state updates on posedge
//   reset    in   1   synchronous, active-high; clears all state
//   rd1E     in   32  operand A (rs), already forwarded
//   rd2E     in   32  operand B (rt), already forwarded
//   md_op    in   3   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 none
//   Req      in   1   exception/interrupt request; suppresses the E-stage op this cycle
//   busy     out  1   operation in flight (start cycle excluded)
//   start    out  1   comb: md_op in 1..4 && !Req && !busy
//   hi       out  32  HI register
//   lo       out  32  LO register
// BEHAVIOUR
//   Reset: busy=0, hi=0, lo=0, internal counter=0, temp result=0. Reset beats all others.
//   States: IDLE (busy=0), RUN (busy=1, counter>0).
//   IDLE, start=1 at edge T: latch result into tmp_hi/tmp_lo; counter<=N (N=MULT_CYCLES
//     or DIV_CYCLES); busy=1 from cycle T+1 through T+N.
//   RUN: counter decrements each edge; at the edge where counter==1: hi<=tmp_hi,
//     lo<=tmp_lo, busy<=0. New hi/lo and busy=0 visible in cycle T+N+1.
//   hi/lo keep old values during RUN (no early update).
//   mult:  {hi,lo} = signed(A)*signed(B), 64-bit. multu: unsigned 64-bit product.
//   div:   lo = signed quotient (truncate toward zero), hi = remainder, sign of A.
//   divu:  unsigned quotient/remainder.
//   Divide by zero (B==0): op still runs DIV_CYCLES busy cycles; hi/lo left unchanged.
//   div 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (no trap).
//   mthi/mtlo with !Req && !busy: hi<=A (resp. lo<=A) at the next edge, no busy.
//   Req=1: md_op ignored this cycle (no start, no mthi/mtlo write).
//   Req does NOT abort an op already in RUN; it completes and commits normally.
//   md_op in 1..6 while busy: ignored (hazard unit stalls these; defensive only).
//   Reset during RUN: op dropped, hi/lo=0, busy=0 next cycle.
//   Hazard contract: D-stage mult/div/mfhi/mflo/mthi/mtlo stall while (start|busy).
//   mfhi/mflo read hi/lo directly; bypassing of in-flight results not provided.
// TESTING
//   reset; mult A=0xFFFFFFFE,B=3 -> busy cycles T+1..T+5, then hi=0xFFFFFFFF, lo=0xFFFFFFFA
//   multu A=0xFFFFFFFF,B=2 -> after 5 busy cycles hi=1, lo=0xFFFFFFFE
//   div A=-7,B=2 -> busy 10 cycles, lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu A=7,B=0 -> hi/lo unchanged
//   mthi A=0x1234 with Req=1 -> hi unchanged, start=0; repeat with Req=0 -> hi=0x1234 next cycle
//   mult started, Req pulsed at T+2 -> op still commits at T+5; new md_op during busy ignored
//   reset asserted at T+3 of divu -> busy=0, hi=lo=0 next cycle; no late commit afterwards

Source files
------------

// File: rtl/e_mdu.sv
// e_mdu: Execute-stage multiply/divide unit owning the HI/LO registers.
// Ports: clk, reset (sync, active-high), rd1E/rd2E operands, md_op,
//   Req (flush request), busy, start (comb), hi, lo.
module e_mdu #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] rd1E,
   input  logic [31:0] rd2E,
   input  logic [2:0]  md_op,
   input  logic        Req,
   output logic        busy,
   output logic        start,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int unsigned MAX_CYCLES =
      (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
   localparam int CW = $clog2(MAX_CYCLES + 1);

   typedef enum logic {
      IDLE,
      RUN
   } state_t;

   state_t        state;
   state_t        state_nxt;
   logic [CW-1:0] cnt;
   logic [31:0]   tmp_hi;
   logic [31:0]   tmp_lo;
   logic          tmp_ok;

   logic          is_mul;
   logic          is_div;
   logic          sgn;
   logic          op_mthi;
   logic          op_mtlo;
   logic          idle;
   logic          load;
   logic          commit;
   logic          wr_hi;
   logic          wr_lo;

   logic [63:0]   a_sx;
   logic [63:0]   b_sx;
   logic [63:0]   prod_s;
   logic [63:0]   prod_u;

   logic          a_neg;
   logic          b_neg;
   logic [31:0]   dvd;
   logic [31:0]   dvs;
   logic [31:0]   uq;
   logic [31:0]   ur;
   logic [31:0]   quo;
   logic [31:0]   rem;

   logic [63:0]   res;
   logic          res_ok;

   // Operation decode
   always_comb begin
      is_mul  = 1'b0;
      is_div  = 1'b0;
      sgn     = 1'b0;
      op_mthi = 1'b0;
      op_mtlo = 1'b0;
      unique case (md_op)
         3'd1: begin
            is_mul = 1'b1;
            sgn    = 1'b1;
         end
         3'd2: is_mul = 1'b1;
         3'd3: begin
            is_div = 1'b1;
            sgn    = 1'b1;
         end
         3'd4: is_div  = 1'b1;
         3'd5: op_mthi = 1'b1;
         3'd6: op_mtlo = 1'b1;
         default: ;
      endcase
   end

   assign idle  = (state == IDLE);
   assign busy  = (state == RUN);
   assign start = (is_mul | is_div) & ~Req & idle;
   assign wr_hi = op_mthi & ~Req & idle;
   assign wr_lo = op_mtlo & ~Req & idle;

   // Multiply: both operands widened to 64 bits first
   assign a_sx   = {{32{rd1E[31]}}, rd1E};
   assign b_sx   = {{32{rd2E[31]}}, rd2E};
   assign prod_s = a_sx * b_sx;
   assign prod_u = {32'd0, rd1E} * {32'd0, rd2E};

   // Divide on magnitudes, then restore signs. This keeps
   // 0x80000000 / -1 well defined (quotient wraps, rem 0).
   assign a_neg = sgn & rd1E[31];
   assign b_neg = sgn & rd2E[31];
   assign dvd   = a_neg ? (32'd0 - rd1E) : rd1E;
   assign dvs   = b_neg ? (32'd0 - rd2E) : rd2E;
   assign uq    = (dvs == 32'd0) ? 32'd0 : (dvd / dvs);
   assign ur    = (dvs == 32'd0) ? 32'd0 : (dvd % dvs);
   assign quo   = (a_neg ^ b_neg) ? (32'd0 - uq) : uq;
   assign rem   = a_neg ? (32'd0 - ur) : ur;

   always_comb begin
      res    = {rem, quo};
      res_ok = (rd2E != 32'd0);
      if (is_mul) begin
         res    = sgn ? prod_s : prod_u;
         res_ok = 1'b1;
      end
   end

   // FSM state register
   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // FSM next state and control
   always_comb begin
      state_nxt = state;
      load      = 1'b0;
      commit    = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt = RUN;
               load      = 1'b1;
            end
         end
         RUN: begin
            if (cnt == CW'(1)) begin
               state_nxt = IDLE;
               commit    = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Latency counter
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt <= '0;
      end else if (load) begin
         cnt <= is_mul ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
      end else if (busy) begin
         cnt <= cnt - CW'(1);
      end
   end

   // Result staging and HI/LO
   always_ff @(posedge clk) begin
      if (reset) begin
         tmp_hi <= '0;
         tmp_lo <= '0;
         tmp_ok <= 1'b0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         if (load) begin
            tmp_hi <= res[63:32];
            tmp_lo <= res[31:0];
            tmp_ok <= res_ok;
         end
         // divide by zero commits nothing
         if (commit) begin
            if (tmp_ok) begin
               hi <= tmp_hi;
               lo <= tmp_lo;
            end
         end else begin
            if (wr_hi) hi <= rd1E;
            if (wr_lo) lo <= rd1E;
         end
      end
   end

endmodule

// File: tb/tb_e_mdu.sv
// tb_e_mdu: directed scoreboard bench for e_mdu.
// Drives/samples on the falling clock edge.
module tb_e_mdu;

   logic        clk;
   logic        reset;
   logic [31:0] rd1E;
   logic [31:0] rd2E;
   logic [2:0]  md_op;
   logic        Req;
   logic        busy;
   logic        start;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks;
   int failures;
   logic [63:0] sb[$];
   logic [31:0] hi_m;
   logic [31:0] lo_m;

   e_mdu #(
      .MULT_CYCLES(5),
      .DIV_CYCLES(10)
   ) dut (
      .clk(clk),
      .reset(reset),
      .rd1E(rd1E),
      .rd2E(rd2E),
      .md_op(md_op),
      .Req(Req),
      .busy(busy),
      .start(start),
      .hi(hi),
      .lo(lo)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [63:0] obs,
                        input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic run_op(input string tag, input logic [2:0] op,
                         input logic [31:0] a, input logic [31:0] b,
                         input int n, input logic [31:0] eh,
                         input logic [31:0] el);
      logic [63:0] r;
      int cyc;
      @(negedge clk);
      md_op = op;
      rd1E  = a;
      rd2E  = b;
      Req   = 1'b0;
      #1 check({tag, "_start"}, 64'(start), 64'd1);
      sb.push_back({eh, el});
      @(negedge clk);
      md_op = 3'd0;
      check({tag, "_hold"}, {hi, lo}, {hi_m, lo_m});
      cyc = 0;
      while (busy === 1'b1 && cyc < 100) begin
         cyc++;
         @(negedge clk);
      end
      check({tag, "_busy_cycles"}, 64'(cyc), 64'(n));
      r = sb.pop_front();
      check({tag, "_hilo"}, {hi, lo}, r);
      hi_m = eh;
      lo_m = el;
   endtask

   initial begin
      logic [31:0] ra;
      logic [31:0] rb;
      logic [63:0] p;
      logic [63:0] r;
      checks   = 0;
      failures = 0;
      reset = 1'b1;
      rd1E  = '0;
      rd2E  = '0;
      md_op = 3'd0;
      Req   = 1'b0;
      hi_m  = '0;
      lo_m  = '0;
      repeat (3) @(negedge clk);
      check("reset_state", {31'd0, busy, hi, lo}, 64'd0);
      reset = 1'b0;
      @(negedge clk);
      check("idle_start", 64'(start), 64'd0);

      run_op("mult", 3'd1, 32'hFFFF_FFFE, 32'd3, 5,
             32'hFFFF_FFFF, 32'hFFFF_FFFA);
      run_op("multu", 3'd2, 32'hFFFF_FFFF, 32'd2, 5,
             32'h0000_0001, 32'hFFFF_FFFE);
      run_op("div", 3'd3, 32'hFFFF_FFF9, 32'd2, 10,
             32'hFFFF_FFFF, 32'hFFFF_FFFD);
      run_op("divu_by0", 3'd4, 32'd7, 32'd0, 10, hi_m, lo_m);
      run_op("div_ovf", 3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10,
             32'd0, 32'h8000_0000);
      run_op("divu", 3'd4, 32'd100, 32'd7, 10, 32'd2, 32'd14);
      run_op("div_rneg", 3'd3, 32'd7, 32'hFFFF_FFFE, 10,
             32'd1, 32'hFFFF_FFFD);

      for (int i = 0; i < 3; i++) begin
         ra = $urandom;
         rb = $urandom;
         p  = 64'(ra) * 64'(rb);
         run_op("multu_rand", 3'd2, ra, rb, 5, p[63:32], p[31:0]);
      end

      // mthi blocked by Req, then accepted
      @(negedge clk);
      md_op = 3'd5;
      rd1E  = 32'h1234;
      Req   = 1'b1;
      #1 check("mthi_req_start", 64'(start), 64'd0);
      @(negedge clk);
      md_op = 3'd0;
      Req   = 1'b0;
      check("mthi_req_hi", 64'(hi), 64'(hi_m));
      md_op = 3'd5;
      #1 check("mthi_start", 64'(start), 64'd0);
      @(negedge clk);
      md_op = 3'd6;
      rd1E  = 32'h5678;
      check("mthi_hi", {31'd0, busy, hi}, {31'd0, 1'b0, 32'h1234});
      hi_m = 32'h1234;
      @(negedge clk);
      md_op = 3'd0;
      check("mtlo_lo", {hi, lo}, {hi_m, 32'h5678});
      lo_m = 32'h5678;

      // Req pulsed mid-run; new ops during busy ignored
      @(negedge clk);
      md_op = 3'd1;
      rd1E  = 32'd7;
      rd2E  = 32'hFFFF_FFFD;
      #1 check("req_mid_start", 64'(start), 64'd1);
      sb.push_back({32'hFFFF_FFFF, 32'hFFFF_FFEB});
      @(negedge clk);
      md_op = 3'd5;
      rd1E  = 32'hDEAD;
      #1 check("busy_mthi_start", {62'd0, busy, start}, 64'd2);
      @(negedge clk);
      md_op = 3'd1;
      Req   = 1'b1;
      #1 check("busy_mult_start", 64'(start), 64'd0);
      @(negedge clk);
      md_op = 3'd6;
      Req   = 1'b0;
      @(negedge clk);
      md_op = 3'd0;
      @(negedge clk);
      check("req_mid_hold", {31'd0, busy, hi, lo},
            {31'd0, 1'b1, hi_m, lo_m});
      @(negedge clk);
      check("req_mid_done", 64'(busy), 64'd0);
      r = sb.pop_front();
      check("req_mid_hilo", {hi, lo}, r);
      hi_m = r[63:32];
      lo_m = r[31:0];

      // reset during a divide
      @(negedge clk);
      md_op = 3'd4;
      rd1E  = 32'd100;
      rd2E  = 32'd7;
      @(negedge clk);
      md_op = 3'd0;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check("rst_run", {31'd0, busy, hi, lo}, 64'd0);
      repeat (12) @(negedge clk);
      check("rst_no_late", {31'd0, busy, hi, lo}, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
